// File: rtl/motor_pkg.sv
// motor_pkg: shared scheduler states, level limit, step-period math and coil phase table
package motor_pkg;
  typedef enum logic [1:0] {IDLE, RUN, STOP, REV} sched_state_t;
  localparam int MAX_LEVEL = 5;
  localparam logic [3:0] PHASE_TABLE [8] = '{
    4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001
  };
  // 64-bit intermediate: CLK_HZ*60 overflows 32 bits at 50 MHz
  function automatic int step_period(input int level, input int clk_hz, input int spr);
    return int'((longint'(clk_hz) * 60) / (longint'(level + 1) * 10 * spr));
  endfunction
endpackage

// File: rtl/step_phase_seq.sv
// step_phase_seq: coil phase index register and coil drive
module step_phase_seq
  import motor_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       start,
  input  logic       adv,
  input  logic       dir,
  input  logic       half_step,
  output logic [3:0] coils
);
  logic [2:0] idx;
  logic [2:0] stride;
  assign stride = half_step ? 3'd1 : 3'd2;
  // full-step runs on odd indices only, so an even index is snapped on start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) idx <= 3'd1;
    else if (start) idx <= half_step ? idx : (idx | 3'd1);
    else if (adv) idx <= dir ? idx + stride : idx - stride;
  end
  assign coils = en ? PHASE_TABLE[idx] : 4'b0000;
endmodule

// File: rtl/step_rate_scheduler.sv
// step_rate_scheduler: speed-level ramping, direction reversal and step timing for the stepper
module step_rate_scheduler
  import motor_pkg::*;
#(
  parameter int CLK_HZ        = 50_000_000,
  parameter int STEPS_PER_REV = 200,
  parameter int RAMP_STEPS    = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       dir,
  input  logic       half_step,
  input  logic [2:0] speed_value,
  output logic [3:0] coils,
  output logic       step_tick,
  output logic [2:0] cur_level,
  output logic       at_speed,
  output logic       busy
);
  localparam int P0 = step_period(0, CLK_HZ, STEPS_PER_REV);
  localparam int CW = $clog2(P0 + 1);
  localparam int RW = RAMP_STEPS > 1 ? $clog2(RAMP_STEPS) : 1;
  sched_state_t state, state_n;
  logic [CW-1:0] cnt, per;
  logic [CW-1:0] per_tab [MAX_LEVEL+1];
  logic [RW-1:0] ramp;
  logic [2:0] lvl, lvl_n, target;
  logic dir_l, half_l, tick, ramp_done, start, flip, mode_half;
  for (genvar i = 0; i <= MAX_LEVEL; i++) begin : g_per
    assign per_tab[i] = CW'(step_period(i, CLK_HZ, STEPS_PER_REV));
  end
  assign busy = state != IDLE;
  always_comb begin
    target = speed_value > 3'(MAX_LEVEL) ? 3'(MAX_LEVEL) : speed_value;
    per = half_l ? per_tab[lvl] >> 1 : per_tab[lvl];
    tick = busy && cnt == per - CW'(1);
    ramp_done = tick && ramp == RW'(RAMP_STEPS - 1);
    state_n = state;
    lvl_n = lvl;
    unique case (state)
      IDLE: state_n = enable ? RUN : IDLE;
      RUN: begin
        state_n = !enable ? STOP : (dir != dir_l) ? REV : RUN;
        if (ramp_done && lvl != target) lvl_n = lvl < target ? lvl + 3'd1 : lvl - 3'd1;
      end
      STOP: begin
        state_n = enable ? RUN : (ramp_done && lvl == 3'd0) ? IDLE : STOP;
        if (ramp_done && lvl != 3'd0) lvl_n = lvl - 3'd1;
      end
      REV: begin
        state_n = !enable ? STOP : (ramp_done && lvl == 3'd0) ? RUN : REV;
        if (ramp_done && lvl != 3'd0) lvl_n = lvl - 3'd1;
      end
    endcase
    start = state == IDLE && enable;
    flip = state == REV && state_n == RUN;
    mode_half = state == IDLE ? half_step : half_l;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      ramp   <= '0;
      lvl    <= '0;
      dir_l  <= 1'b1;
      half_l <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= (state == IDLE || tick) ? '0 : cnt + CW'(1);
      ramp  <= (state == IDLE || ramp_done || ((state_n == STOP || state_n == REV) && state_n != state))
               ? '0 : tick ? ramp + RW'(1) : ramp;
      lvl   <= lvl_n;
      if (start) begin
        dir_l  <= dir;
        half_l <= half_step;
      end else if (flip) dir_l <= !dir_l;
    end
  end
  step_phase_seq u_phase (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (busy),
    .start     (start),
    .adv       (tick),
    .dir       (dir_l),
    .half_step (mode_half),
    .coils     (coils)
  );
  assign step_tick = tick;
  assign cur_level = lvl;
  assign at_speed  = state == RUN && lvl == target;
endmodule
